// File: rtl/tcdm_resp_unit.sv
// tcdm_resp_unit: TCDM bank-side request pass-through and single-cycle response generator.
// Forwards the arbitration-tree root request to the memory bank and returns a one-hot
// response exactly one cycle after every accepted request. It also advances a
// round-robin priority vector on each accept, and sets a sticky flag for non-one-hot IDs.
//
// Ports
//   clk, rst                     : clock and synchronous active-high reset
//   data_req_i .. data_ID_i      : request from the arbitration tree root
//   data_gnt_o                   : grant to the arbitration tree root
//   mem_req_o .. mem_be_o        : bank request (combinational copy of data_*_i)
//   mem_gnt_i, mem_rdata_i       : bank grant and next-cycle read data
//   data_r_valid_o               : one-hot response valid, one bit per master
//   data_r_rdata_o, data_r_ID_o  : response data and ID
//   RR_FLAG_o                    : round-robin priority vector for the request tree
//   id_err_o                     : sticky error, an accepted request had a non-one-hot ID
module tcdm_resp_unit #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 16,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8,
  parameter int unsigned RR_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  data_req_i,
  input  logic [ADDR_WIDTH-1:0] data_add_i,
  input  logic                  data_wen_i,
  input  logic [DATA_WIDTH-1:0] data_wdata_i,
  input  logic [BE_WIDTH-1:0]   data_be_i,
  input  logic [ID_WIDTH-1:0]   data_ID_i,
  output logic                  data_gnt_o,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_add_o,
  output logic                  mem_wen_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic [BE_WIDTH-1:0]   mem_be_o,
  input  logic                  mem_gnt_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic [ID_WIDTH-1:0]   data_r_valid_o,
  output logic [DATA_WIDTH-1:0] data_r_rdata_o,
  output logic [ID_WIDTH-1:0]   data_r_ID_o,
  output logic [RR_WIDTH-1:0]   RR_FLAG_o,
  output logic                  id_err_o
);

  logic                w_accept;
  logic [ID_WIDTH-1:0] w_id_m1;
  logic                w_id_onehot;

  logic                r_valid;
  logic [ID_WIDTH-1:0] r_id;
  logic                r_id_ok;
  logic                r_wen;
  logic [RR_WIDTH-1:0] r_rr;
  logic                r_id_err;

  // Request path is a straight combinational pass-through, also during reset.
  assign mem_req_o   = data_req_i;
  assign mem_add_o   = data_add_i;
  assign mem_wen_o   = data_wen_i;
  assign mem_wdata_o = data_wdata_i;
  assign mem_be_o    = data_be_i;
  assign data_gnt_o  = data_req_i & mem_gnt_i;
  assign w_accept    = data_req_i & data_gnt_o;

  // One-hot test: nonzero and clearing the lowest set bit leaves nothing.
  assign w_id_m1     = data_ID_i - ID_WIDTH'(1);
  assign w_id_onehot = (data_ID_i != '0) && ((data_ID_i & w_id_m1) == '0);

  // Response slot, round-robin counter and sticky ID error.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_id     <= '0;
      r_id_ok  <= 1'b0;
      r_wen    <= 1'b0;
      r_rr     <= '0;
      r_id_err <= 1'b0;
    end else begin
      r_valid <= w_accept;
      if (w_accept) begin
        r_id    <= data_ID_i;
        r_id_ok <= w_id_onehot;
        r_wen   <= data_wen_i;
        r_rr    <= r_rr + RR_WIDTH'(1);
        if (!w_id_onehot) begin
          r_id_err <= 1'b1;
        end
      end
    end
  end

  // A bad ID still occupies the response slot but raises no valid bit.
  assign data_r_valid_o = (r_valid && r_id_ok) ? r_id : '0;
  assign data_r_ID_o    = r_valid ? r_id : '0;
  // Write responses return zero data.
  assign data_r_rdata_o = (r_valid && r_wen) ? mem_rdata_i : '0;
  assign RR_FLAG_o      = r_rr;
  assign id_err_o       = r_id_err;

endmodule
